// File: rtl/param_datapath_pkg.sv
// param_datapath_pkg: shared types, FSM encoding and ALU/shift helpers for param_datapath
package param_datapath_pkg;

    // Helpers work on a wide word; callers zero-extend operands and truncate results to DATA_W
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_MVN} alu_op_e;
    typedef enum logic [1:0] {SH_NONE, SH_LSL, SH_LSR, SH_ASR} shift_e;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_RD_A = S_RD_A,
        ST_RD_B = S_RD_B,
        ST_EXEC = S_EXEC,
        ST_WB   = S_WB
    } state_e;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
    } flags_t;

    // One-bit shift of a w-bit value; ASR replicates bit w-1
    function automatic word_t shift_fn(input word_t b, input shift_e s, input int w);
        return s == SH_LSL ? b << 1 :
               s == SH_LSR ? b >> 1 :
               s == SH_ASR ? (b >> 1) | (word_t'(b[w-1]) << (w - 1)) : b;
    endfunction

    function automatic word_t alu_fn(input word_t a, input word_t b, input alu_op_e op);
        return op == OP_ADD ? a + b :
               op == OP_SUB ? a - b :
               op == OP_AND ? a & b : ~b;
    endfunction

    // r must already be truncated to w bits and zero-extended
    function automatic flags_t flags_fn(input word_t a, input word_t b, input word_t r,
                                        input alu_op_e op, input int w);
        flags_t f;
        f.n = r[w-1];
        f.z = (r == '0);
        f.v = op == OP_ADD ? (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]) :
              op == OP_SUB ? (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]) : 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/param_datapath_regfile.sv
// pd_regfile: NREGS x DATA_W register file, one write port, one or two read ports plus debug read
// Second read port present only when PARAM_DATAPATH_DUAL_READ_EN is defined.
module pd_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [AW-1:0]     ra0,
    output logic [DATA_W-1:0] rd0,
`ifdef PARAM_DATAPATH_DUAL_READ_EN
    input  logic [AW-1:0]     ra1,
    output logic [DATA_W-1:0] rd1,
`endif
    input  logic [AW-1:0]     dbg_num,
    output logic [DATA_W-1:0] dbg_data
);

    logic [NREGS-1:0][DATA_W-1:0] mem;

    // Storage: cleared by reset, single write per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mem <= '0;
        else if (we)
            mem[wa] <= wd;
    end

    assign rd0      = mem[ra0];
    assign dbg_data = mem[dbg_num];
`ifdef PARAM_DATAPATH_DUAL_READ_EN
    assign rd1      = mem[ra1];
`endif

endmodule

// File: rtl/param_datapath.sv
// param_datapath: self-sequencing register-file/shifter/ALU datapath driven by start/done
// Define PARAM_DATAPATH_DUAL_READ_EN to read A and B together and drop the RD_B state.
module param_datapath
    import param_datapath_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [1:0]        shift,
    input  logic [AW-1:0]     rn,
    input  logic [AW-1:0]     rm,
    input  logic [AW-1:0]     rd,
    input  logic              a_zero,
    input  logic              b_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic              wb_en,
    input  logic              flags_en,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_num,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [AW-1:0]     dbg_num,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              N,
    output logic              V,
    output logic              Z
);

    logic [2:0]        state;
    alu_op_e           op_q;
    shift_e            sh_q;
    logic [AW-1:0]     rn_q, rm_q, rd_q;
    logic              a_zero_q, b_imm_q, wb_en_q, flags_en_q, done_q;
    logic [DATA_W-1:0] imm_q, a_q, b_q, c_q;
    flags_t            flg;

    logic              we;
    logic [AW-1:0]     wa, ra0;
    logic [DATA_W-1:0] wd, rd0, b_op, c_next;

    // Writeback owns the port outside IDLE; direct loads only land while idle
    assign we  = (state == S_WB && wb_en_q) || (state == S_IDLE && ld_en);
    assign wa  = state == S_WB ? rd_q : ld_num;
    assign wd  = state == S_WB ? c_q : ld_data;

    assign b_op   = b_imm_q ? imm_q : DATA_W'(shift_fn(word_t'(b_q), sh_q, DATA_W));
    assign c_next = DATA_W'(alu_fn(word_t'(a_q), word_t'(b_op), op_q));

`ifdef PARAM_DATAPATH_DUAL_READ_EN
    logic [DATA_W-1:0] rd1;
    assign ra0 = rn_q;
    pd_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra0(ra0), .rd0(rd0), .ra1(rm_q), .rd1(rd1),
        .dbg_num(dbg_num), .dbg_data(dbg_data)
    );
`else
    assign ra0 = state == S_RD_A ? rn_q : rm_q;
    pd_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra0(ra0), .rd0(rd0),
        .dbg_num(dbg_num), .dbg_data(dbg_data)
    );
`endif

    // Sequencer: latch command on start in IDLE, then read, execute and write back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            done_q     <= 1'b0;
            op_q       <= OP_ADD;
            sh_q       <= SH_NONE;
            rn_q       <= '0;
            rm_q       <= '0;
            rd_q       <= '0;
            a_zero_q   <= 1'b0;
            b_imm_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            flags_en_q <= 1'b0;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            flg        <= '0;
        end else begin
            done_q <= (state == S_WB);
            case (state)
                S_IDLE: if (start) begin
                    op_q       <= alu_op_e'(op);
                    sh_q       <= shift_e'(shift);
                    rn_q       <= rn;
                    rm_q       <= rm;
                    rd_q       <= rd;
                    a_zero_q   <= a_zero;
                    b_imm_q    <= b_imm;
                    wb_en_q    <= wb_en;
                    flags_en_q <= flags_en;
                    imm_q      <= imm;
                    state      <= S_RD_A;
                end
                S_RD_A: begin
                    a_q   <= a_zero_q ? '0 : rd0;
`ifdef PARAM_DATAPATH_DUAL_READ_EN
                    b_q   <= rd1;
                    state <= S_EXEC;
`else
                    state <= S_RD_B;
`endif
                end
                S_RD_B: begin
                    b_q   <= rd0;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    c_q   <= c_next;
                    if (flags_en_q)
                        flg <= flags_fn(word_t'(a_q), word_t'(b_op), word_t'(c_next), op_q, DATA_W);
                    state <= S_WB;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = done_q;
    assign result = c_q;
    assign N      = flg.n;
    assign V      = flg.v;
    assign Z      = flg.z;

endmodule

// File: doc/param_datapath.md
# param_datapath

Parametrised, self-sequencing successor to the 16-bit lab datapath: a DATA_W-bit register file of NREGS entries feeding operand registers A/B, a barrel-free 1-bit shifter, a 4-op ALU, result register C and N/V/Z status. It replaces the externally micro-stepped loada/loadb/loadc/write control with an internal start/done sequencer. It sits under the CPU controller, which issues one register-register or register-immediate operation per start pulse.

## Interface
- DATA_W, 16, datapath width (≥4)
- NREGS, 8, register count (power of two ≥2); localparam AW = $clog2(NREGS)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request operation; sampled only in IDLE
- op  in  2  00 ADD, 01 SUB (A−B), 10 AND, 11 MVN (~B)
- shift  in  2  applied to Rm operand only: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
- rn, rm, rd  in  AW  A source, B source, destination
- a_zero  in  1  A operand forced to 0
- b_imm  in  1  B operand = imm (unshifted) instead of shifted Rm
- imm  in  DATA_W  pre-sign-extended immediate
- wb_en  in  1  write C to Rd at end of operation
- flags_en  in  1  update N/V/Z in EXEC
- ld_en, ld_num (AW), ld_data (DATA_W)  in  direct register load, honoured only when idle
- dbg_num  in  AW; dbg_data  out  DATA_W  combinational read of R[dbg_num]
- busy  out  1; done  out  1; result  out  DATA_W (C); N, V, Z  out  1 each

## Operation
- States IDLE → RD_A → RD_B → EXEC → WB → IDLE. Command fields latched on the edge that samples start in IDLE.
- RD_A: A ← a_zero ? 0 : R[rn]. RD_B: B ← R[rm]. EXEC: C ← ALU(A, b_imm ? imm : shift(B)); flags if flags_en. WB: R[rd] ← C if wb_en.
- Arithmetic modulo 2^DATA_W. Z = (C==0), N = C[DATA_W−1]. V for ADD: operand signs equal and result sign differs; SUB: operand signs differ and result sign ≠ A sign; AND/MVN: V=0.
- ld_en in IDLE writes R[ld_num] on that edge; with simultaneous start, the load completes first and RD_A/RD_B observe it. ld_en while busy ignored.
- start while busy ignored (no queueing).
- Reset values: all registers, A, B, C, N, V, Z = 0; busy=0, done=0, state IDLE. Reset mid-operation aborts with no writeback.

## Timing
- Edge 0 samples start; busy high from edge 0 until edge 4; result/flags valid after edge 3; Rd written at edge 4; done high exactly one cycle after edge 4.
- Back-to-back: start may be asserted in the done cycle and is sampled (state already IDLE).
- dbg_data reflects a writeback in the cycle after the writing edge.

## Configuration
- PARAM_DATAPATH_DUAL_READ_EN defined: register file has two read ports; RD_B is removed, A and B load together; done follows edge 3 (one cycle shorter), busy spans edges 0–3.
- Undefined: single read port, five-state sequence above.

## Structure
- Package param_datapath_pkg: alu_op_e, shift_e, state_e enums, flags struct {N,V,Z}, ALU and shift functions.
- Sub-module pd_regfile: NREGS×DATA_W, one write port (writeback or ld), one or two read ports plus debug port, async reset.

## Test plan
- ld R0=7, R1=2; start ADD rn=1 rm=0 LSL1 rd=2 wb_en flags_en → result 16, NZV=000, R2=16, done one cycle after edge 4.
- R3=0x7FFF, imm=1, b_imm ADD → 0x8000, N=1 V=1 Z=0; SUB R0−R0 → Z=1, N=0, V=0.
- R4=0x8000, MVN with ASR1 → B'=0xC000, result 0x3FFF; LSR1 path → 0xBFFF.
- start held during busy → single done pulse, second start ignored; ld_en mid-operation leaves target unchanged.
- reset asserted in EXEC → immediate busy=0, result=0, flags=0, R[rd] not written.
- Repeat first scenario with PARAM_DATAPATH_DUAL_READ_EN → same values, done one cycle earlier.
